// File: rtl/div3_frame_tx.sv
// Serial frame source for the MSB-first divide-by-3 checker: shifts out a WIDTH-bit word
// followed by a 2-bit pad that makes the whole (WIDTH+2)-bit number a multiple of 3.
module div3_frame_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] PAD1 = 2'd2;
  localparam logic [1:0] PAD2 = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       residue;
  logic             pad_lo;
  logic [1:0]       pad_bits;
  logic             xfer;

  // Residue of the MSB-first prefix after appending bit b; the unreachable code 3 recovers to 0.
  function automatic logic [1:0] next_residue(input logic [1:0] r, input logic b);
    case (r)
      2'd0:    next_residue = b ? 2'd1 : 2'd0;
      2'd1:    next_residue = b ? 2'd0 : 2'd2;
      2'd2:    next_residue = b ? 2'd2 : 2'd1;
      default: next_residue = 2'd0;
    endcase
  endfunction

  // Pad p with (4*payload + p) mod 3 == 0, i.e. p = (3 - r) mod 3.
  function automatic logic [1:0] pad_for(input logic [1:0] r);
    case (r)
      2'd1:    pad_for = 2'b10;
      2'd2:    pad_for = 2'b01;
      default: pad_for = 2'b00;
    endcase
  endfunction

  assign pad_bits  = pad_for(residue);
  assign din_ready = (state == IDLE) || (state == PAD2);
  assign xfer      = din_valid & din_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      residue <= 2'd0;
      pad_lo  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            shreg   <= din;
            residue <= 2'd0;
            cnt     <= CNT_W'(WIDTH - 1);
            state   <= DATA;
          end
        end
        DATA: begin
          shreg   <= shreg << 1;
          cnt     <= cnt - 1'b1;
          residue <= next_residue(residue, shreg[WIDTH-1]);
          if (cnt == '0) state <= PAD1;
        end
        PAD1: begin
          pad_lo <= pad_bits[0];
          state  <= PAD2;
        end
        default: begin
          // Accepting here lets the next frame follow with no idle gap.
          if (xfer) begin
            shreg   <= din;
            residue <= 2'd0;
            cnt     <= CNT_W'(WIDTH - 1);
            state   <= DATA;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    dout       = 1'b0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    case (state)
      DATA: begin
        dout       = shreg[WIDTH-1];
        dout_valid = 1'b1;
      end
      PAD1: begin
        dout       = pad_bits[1];
        dout_valid = 1'b1;
      end
      PAD2: begin
        dout       = pad_lo;
        dout_valid = 1'b1;
        dout_last  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div3_frame_tx.sv
// Bench for div3_frame_tx at WIDTH=8 and WIDTH=3: cycle-level frame model plus per-frame
// arithmetic checks (value, length, divisibility, pad).
module tb_div3_frame_tx;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] din8;
  logic       din_valid8;
  logic       din_ready8, dout8, dout_valid8, dout_last8;
  logic [2:0] din3;
  logic       din_valid3;
  logic       din_ready3, dout3, dout_valid3, dout_last3;

  always #5 clk = ~clk;

  div3_frame_tx #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .din(din8), .din_valid(din_valid8), .din_ready(din_ready8),
    .dout(dout8), .dout_valid(dout_valid8), .dout_last(dout_last8)
  );

  div3_frame_tx #(.WIDTH(3)) dut3 (
    .clk(clk), .resetn(resetn), .din(din3), .din_valid(din_valid3), .din_ready(din_ready3),
    .dout(dout3), .dout_valid(dout_valid3), .dout_last(dout_last3)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: position within frame (0 = idle, 1..W+2 = bit index) and the captured word.
  int    wid[2] = '{8, 3};
  int    pos[2] = '{0, 0};
  longint word[2] = '{0, 0};
  // Frame monitor state.
  longint acc[2] = '{0, 0};
  int     nbits[2] = '{0, 0};
  longint exp_val_q[$];
  longint exp_pad_q[$];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint frame_val(input longint w);
    return w * 4 + (3 - (w % 3)) % 3;
  endfunction

  task automatic tick(input logic rn, input logic v8, input logic [7:0] d8,
                      input logic v3, input logic [2:0] d3);
    logic ov[2], ob[2], ol[2], orr[2];
    logic vin[2];
    longint din_w[2];
    resetn = rn; din_valid8 = v8; din8 = d8; din_valid3 = v3; din3 = d3;
    vin[0] = v8; vin[1] = v3; din_w[0] = d8; din_w[1] = d3;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rn) pos[i] = 0;
      else if (vin[i] && (pos[i] == 0 || pos[i] == wid[i] + 2)) begin
        word[i] = din_w[i];
        pos[i] = 1;
      end else if (pos[i] == wid[i] + 2) pos[i] = 0;
      else if (pos[i] > 0) pos[i]++;
    end
    @(negedge clk);
    ov[0] = dout_valid8; ob[0] = dout8; ol[0] = dout_last8; orr[0] = din_ready8;
    ov[1] = dout_valid3; ob[1] = dout3; ol[1] = dout_last3; orr[1] = din_ready3;
    for (int i = 0; i < 2; i++) begin
      int w = wid[i];
      logic eb;
      eb = (pos[i] > 0) ? logic'((frame_val(word[i]) >> (w + 2 - pos[i])) & 1) : 1'b0;
      chk($sformatf("w%0d_valid", w), ov[i], pos[i] > 0);
      chk($sformatf("w%0d_dout", w), ob[i], eb);
      chk($sformatf("w%0d_last", w), ol[i], pos[i] == w + 2);
      chk($sformatf("w%0d_ready", w), orr[i], (pos[i] == 0) || (pos[i] == w + 2));
      if (!rn) begin
        acc[i] = 0; nbits[i] = 0;
      end else if (ov[i] === 1'b1) begin
        acc[i] = acc[i] * 2 + longint'(ob[i]);
        nbits[i]++;
        if (ol[i] === 1'b1) begin
          chk($sformatf("w%0d_mod3", w), acc[i] % 3, 0);
          chk($sformatf("w%0d_len", w), nbits[i], w + 2);
          if (i == 0 && exp_val_q.size() > 0) chk("w8_frame", acc[i], exp_val_q.pop_front());
          if (i == 1 && exp_pad_q.size() > 0) chk("w3_pad", acc[i] & 3, exp_pad_q.pop_front());
          acc[i] = 0; nbits[i] = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
  endtask

  task automatic send8(input logic [7:0] d, input longint expv);
    exp_val_q.push_back(expv);
    tick(1'b1, 1'b1, d, 1'b0, 3'd0);
    idle(11);
  endtask

  initial begin
    longint pads[8] = '{0, 2, 1, 0, 2, 1, 0, 2};
    tick(1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
    tick(1'b0, 1'b1, 8'h5A, 1'b1, 3'd5);
    idle(2);

    send8(8'h05, 21);
    send8(8'h07, 30);
    send8(8'h00, 0);
    send8(8'hFF, 1020);

    // Back-to-back with din_valid held high.
    exp_val_q.push_back(21); exp_val_q.push_back(30);
    for (int k = 0; k < 10; k++) tick(1'b1, 1'b1, 8'h05, 1'b0, 3'd0);
    tick(1'b1, 1'b1, 8'h07, 1'b0, 3'd0);
    idle(12);

    // Offers while busy are ignored; 8'hAA is taken at the last bit.
    exp_val_q.push_back(21); exp_val_q.push_back(681);
    tick(1'b1, 1'b1, 8'h05, 1'b0, 3'd0);
    for (int k = 0; k < 10; k++) tick(1'b1, 1'b1, 8'hAA, 1'b0, 3'd0);
    idle(12);

    // Reset mid-frame, then a fresh frame.
    tick(1'b1, 1'b1, 8'h05, 1'b0, 3'd0);
    idle(3);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
    idle(2);
    send8(8'h01, 6);

    // WIDTH=3 exhaustive pads.
    for (int d = 0; d < 8; d++) begin
      exp_pad_q.push_back(pads[d]);
      tick(1'b1, 1'b0, 8'h00, 1'b1, 3'(d));
      idle(6);
    end

    // Random sweep on both widths.
    for (int k = 0; k < 600; k++) begin
      logic rn;
      rn = ($urandom_range(99) != 0);
      tick(rn, logic'($urandom_range(1)), 8'($urandom), logic'($urandom_range(1)), 3'($urandom));
    end
    idle(12);

    chk("w8_queue_drained", exp_val_q.size(), 0);
    chk("w3_queue_drained", exp_pad_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
